vgagraph_rdmaster: RTL and testbench
====================================

Name: vgagraph_rdmaster

Overview:
- AXI4 read master sitting directly downstream of the line-fill controller (vgagraph_ctrl).
- Converts each one-cycle `hstart` pulse into one INCR read burst of BURST_LEN beats from the frame buffer in DDR, and pushes the returned data into the line FIFO.
- Returns an AR-handshake indication (`arready`) to the controller, tracks outstanding bursts, and flags frame completion and bus errors.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (2 pixels of 16 bpp per beat).
- BURST_LEN, 16, beats per burst; ARLEN = BURST_LEN-1.
- MAX_OUTST, 4, maximum outstanding bursts (AR accepted, RLAST not yet received).
- FRAME_BURSTS, 9600, bursts per frame (640*480/(2*16)).

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous active-high reset.
- initiate, in, 1: frame start pulse; latches base_addr.
- base_addr, in, ADDR_W: frame buffer base address, byte aligned to BURST_LEN*DATA_W/8.
- hstart, in, 1: one-cycle burst request from the line-fill controller.
- arready, out, 1: one-cycle pulse on each AR handshake, fed back to the controller.
- m_araddr, out, ADDR_W: AXI read address.
- m_arlen, out, 8: constant BURST_LEN-1.
- m_arsize, out, 3: constant log2(DATA_W/8).
- m_arburst, out, 2: constant 2'b01 (INCR).
- m_arvalid, out, 1: AXI read address valid.
- m_arready, in, 1: AXI read address ready.
- m_rdata, in, DATA_W: AXI read data.
- m_rresp, in, 2: AXI read response.
- m_rlast, in, 1: AXI last beat of burst.
- m_rvalid, in, 1: AXI read data valid.
- m_rready, out, 1: AXI read data ready.
- fifo_afull, in, 1: line FIFO almost full.
- fifo_wr, out, 1: line FIFO write enable.
- fifo_din, out, DATA_W: line FIFO write data.
- frame_done, out, 1: one-cycle pulse when the frame is complete.
- err, out, 1: sticky error flag.

Behaviour:
- **Reset.** RST clears:
  - m_arvalid, arready, fifo_wr, frame_done and err to 0;
  - m_araddr, the burst index, the outstanding counter and the pending flag to 0;
  - the latched base address to 0.
  - RST overrides all other inputs in the same cycle.
- **initiate.**
  - Latches base_addr and clears the burst index and the pending flag.
  - Does not clear err.
  - If m_arvalid is high, it stays high with the old address until the handshake completes (AXI rule). That burst still counts as outstanding but not toward the new frame's index.
- **AR path, 2 states IDLE / ADDR.**
  - IDLE -> ADDR: when a request is present (hstart this cycle, or the pending flag) and outstanding < MAX_OUTST.
  - On entering ADDR, register m_araddr = base + index*BURST_LEN*DATA_W/8 and assert m_arvalid on the next cycle. Latency from hstart to m_arvalid is 1 cycle.
  - ADDR -> IDLE: on m_arvalid & m_arready. In that cycle, pulse arready for 1 cycle, increment the index, and increment outstanding.
  - hstart while in ADDR, or while outstanding == MAX_OUTST: set the pending flag (depth 1).
  - hstart while the pending flag is already set: set err, drop the request.
  - Address is computed with an ADDR_W-wide add, so it wraps modulo 2^ADDR_W.
- **R path.**
  - m_rready = ~fifo_afull (combinational).
  - fifo_wr = m_rvalid & m_rready; fifo_din = m_rdata (combinational, zero latency).
  - m_rresp != 2'b00 on any accepted beat sets err (sticky until RST).
- **Outstanding counter.**
  - +1 on AR handshake; -1 on an accepted beat with m_rlast.
  - Both in the same cycle: no change.
  - Never exceeds MAX_OUTST. An RLAST beat accepted at outstanding == 0 sets err and the counter stays 0.
- **frame_done.**
  - Pulses 1 cycle when the index equals FRAME_BURSTS and the outstanding counter reaches 0 (transition edge).
  - Fires exactly once per frame.
  - hstart after the index reaches FRAME_BURSTS is ignored; err is not set.

Test Plan:
1. RST, then initiate with base_addr=0x1000_0000, one hstart, m_arready held high -> m_arvalid high 1 cycle later with araddr 0x1000_0000, arlen 15; arready pulses once; 16 R beats with fifo_afull=0 give 16 fifo_wr; outstanding returns to 0.
2. Two hstarts 2 cycles apart with m_arready low for 5 cycles -> second request held pending; after the first handshake the second AR issues with araddr 0x1000_0040; err stays 0. A third hstart during the stall sets err=1.
3. MAX_OUTST=4: five hstarts, no R data returned -> four AR handshakes, fifth pending. After one RLAST beat, the fifth AR issues at 0x1000_0100.
4. fifo_afull asserted mid-burst for 3 cycles -> m_rready=0 and fifo_wr=0 during those cycles; no beat lost; total fifo_wr count = 16.
5. Run FRAME_BURSTS=9600 bursts -> the last araddr is base+0x95FC0; frame_done pulses exactly once after the final RLAST; a further hstart issues no AR.
6. m_rresp=2'b10 on beat 7 -> err=1 and stays high; frame continues; RST clears err.

Source files
------------

// File: rtl/vgagraph_rdmaster.sv
// +--------------------------------------------------------------------------+
// | vgagraph_rdmaster                                                        |
// | AXI4 read master: one INCR burst per hstart, read data to the line FIFO. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vgagraph_rdmaster #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURST_LEN    = 16,
  parameter int MAX_OUTST    = 4,
  parameter int FRAME_BURSTS = 9600
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              initiate,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hstart,
  output logic              arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic              fifo_afull,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_din,
  output logic              frame_done,
  output logic              err
);

  localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
  localparam int IDX_W       = $clog2(FRAME_BURSTS + 1);
  localparam int OUT_W       = $clog2(MAX_OUTST + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BURSTS);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTST);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADDR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  index;
  logic [OUT_W-1:0]  outst;
  logic              pending;
  logic              stale;
  logic              done_fired;

  logic              ar_hs;
  logic              beat;
  logic              last_beat;
  logic              in_flight;
  logic [IDX_W:0]    queued;
  logic              frame_full;
  logic              new_req;
  logic              rlast_err;
  logic [ADDR_W-1:0] next_addr;
  logic [OUT_W-1:0]  outst_nxt;
  logic [IDX_W-1:0]  index_nxt;

  assign m_arlen   = 8'(BURST_LEN - 1);
  assign m_arsize  = 3'($clog2(DATA_W / 8));
  assign m_arburst = 2'b01;

  assign m_rready  = ~fifo_afull;
  assign fifo_wr   = m_rvalid & m_rready;
  assign fifo_din  = m_rdata;

  always_comb begin
    ar_hs      = m_arvalid & m_arready;
    beat       = m_rvalid & m_rready;
    last_beat  = beat & m_rlast;
    // A burst still on AR from the previous frame is not part of this frame's count
    in_flight  = (state == ADDR) && !stale;
    queued     = (IDX_W+1)'(index) + (IDX_W+1)'(in_flight) + (IDX_W+1)'(pending);
    frame_full = queued >= (IDX_W+1)'(FRAME_BURSTS);
    new_req    = hstart && !frame_full && !initiate;
    next_addr  = base_q + ADDR_W'(index) * ADDR_W'(BURST_BYTES);
    rlast_err  = last_beat && !ar_hs && (outst == '0);

    outst_nxt = outst;
    if (ar_hs && !last_beat) begin
      outst_nxt = outst + OUT_W'(1);
    end else if (!ar_hs && last_beat && (outst != '0)) begin
      outst_nxt = outst - OUT_W'(1);
    end

    index_nxt = index;
    if (initiate) begin
      index_nxt = '0;
    end else if ((state == ADDR) && ar_hs && !stale) begin
      index_nxt = index + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      base_q     <= '0;
      index      <= '0;
      outst      <= '0;
      pending    <= 1'b0;
      stale      <= 1'b0;
      done_fired <= 1'b0;
      m_araddr   <= '0;
      m_arvalid  <= 1'b0;
      arready    <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      arready    <= 1'b0;
      frame_done <= 1'b0;
      outst      <= outst_nxt;
      index      <= index_nxt;

      if ((beat && (m_rresp != 2'b00)) || rlast_err) begin
        err <= 1'b1;
      end

      if (!done_fired && (index_nxt == IDX_LAST) && (outst_nxt == '0)) begin
        frame_done <= 1'b1;
        done_fired <= 1'b1;
      end

      if (initiate) begin
        base_q     <= base_addr;
        pending    <= 1'b0;
        done_fired <= 1'b0;
        stale      <= (state == ADDR) && !ar_hs;
      end

      case (state)
        IDLE: begin
          if (!initiate && (new_req || pending) && (outst < OUT_MAX)) begin
            state     <= ADDR;
            m_arvalid <= 1'b1;
            m_araddr  <= next_addr;
            // A fresh hstart arriving while the pending one is consumed takes its place
            pending   <= new_req && pending;
          end else if (new_req) begin
            if (pending) begin
              err <= 1'b1;
            end else begin
              pending <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (ar_hs) begin
            state     <= IDLE;
            m_arvalid <= 1'b0;
            arready   <= 1'b1;
            stale     <= 1'b0;
          end
          if (new_req) begin
            if (pending) begin
              err <= 1'b1;
            end else begin
              pending <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          m_arvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vgagraph_rdmaster.sv
// +--------------------------------------------------------------------------+
// | tb_vgagraph_rdmaster                                                     |
// | Directed self-checking bench for the frame-buffer AXI read master.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vgagraph_rdmaster;

    logic        CLK;
    logic        RST;
    logic        initiate;
    logic [31:0] base_addr;
    logic        hstart;
    logic        arready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        fifo_afull;
    logic        fifo_wr;
    logic [31:0] fifo_din;
    logic        frame_done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_arrdy  = 0;
    int n_done   = 0;

    localparam logic [31:0] BASE = 32'h1000_0000;

    vgagraph_rdmaster dut (
        .CLK        (CLK),
        .RST        (RST),
        .initiate   (initiate),
        .base_addr  (base_addr),
        .hstart     (hstart),
        .arready    (arready),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rlast    (m_rlast),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .fifo_afull (fifo_afull),
        .fifo_wr    (fifo_wr),
        .fifo_din   (fifo_din),
        .frame_done (frame_done),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (fifo_wr)    n_wr++;
        if (arready)    n_arrdy++;
        if (frame_done) n_done++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        hstart     = 1'b0;
        initiate   = 1'b0;
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        m_rresp    = 2'b00;
        fifo_afull = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] base);
        base_addr = base;
        initiate  = 1'b1;
        tick();
        initiate  = 1'b0;
    endtask

    initial begin
        int          wr0;
        int          a0;
        int          d0;
        int          b;
        int          miss;
        logic [31:0] last_addr;

        RST = 1'b1; initiate = 1'b0; base_addr = '0; hstart = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
        m_rvalid = 1'b0; fifo_afull = 1'b0;
        repeat (3) tick();

        n_assert++;
        if (m_arvalid !== 1'b0) begin n_fail++; $error("FAIL rst_arvalid: observed 0x%0h expected 0x0", m_arvalid); end
        n_assert++;
        if (arready !== 1'b0) begin n_fail++; $error("FAIL rst_arready: observed 0x%0h expected 0x0", arready); end
        n_assert++;
        if (frame_done !== 1'b0) begin n_fail++; $error("FAIL rst_frame_done: observed 0x%0h expected 0x0", frame_done); end
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $error("FAIL rst_err: observed 0x%0h expected 0x0", err); end
        n_assert++;
        if (m_araddr !== 32'h0) begin n_fail++; $error("FAIL rst_araddr: observed 0x%0h expected 0x0", m_araddr); end
        n_assert++;
        if (m_arlen !== 8'd15) begin n_fail++; $error("FAIL arlen: observed 0x%0h expected 0xf", m_arlen); end
        n_assert++;
        if (m_arsize !== 3'd2) begin n_fail++; $error("FAIL arsize: observed 0x%0h expected 0x2", m_arsize); end
        n_assert++;
        if (m_arburst !== 2'b01) begin n_fail++; $error("FAIL arburst: observed 0x%0h expected 0x1", m_arburst); end
        n_assert++;
        if (m_rready !== 1'b1) begin n_fail++; $error("FAIL rst_rready: observed 0x%0h expected 0x1", m_rready); end
        RST = 1'b0;

        // Single burst, AR accepted immediately, 16 beats
        start_frame(BASE);
        hstart = 1'b1; m_arready = 1'b1;
        tick();
        hstart = 1'b0;
        n_assert++;
        if (m_arvalid !== 1'b1) begin n_fail++; $error("FAIL t1_arvalid: observed 0x%0h expected 0x1", m_arvalid); end
        n_assert++;
        if (m_araddr !== BASE) begin n_fail++; $error("FAIL t1_araddr: observed 0x%0h expected 0x%0h", m_araddr, BASE); end
        n_assert++;
        if (arready !== 1'b0) begin n_fail++; $error("FAIL t1_arready_early: observed 0x%0h expected 0x0", arready); end
        tick();
        n_assert++;
        if (arready !== 1'b1) begin n_fail++; $error("FAIL t1_arready_pulse: observed 0x%0h expected 0x1", arready); end
        n_assert++;
        if (m_arvalid !== 1'b0) begin n_fail++; $error("FAIL t1_arvalid_drop: observed 0x%0h expected 0x0", m_arvalid); end
        tick();
        n_assert++;
        if (arready !== 1'b0) begin n_fail++; $error("FAIL t1_arready_end: observed 0x%0h expected 0x0", arready); end
        wr0 = n_wr;
        for (int i = 0; i < 16; i++) begin
            m_rvalid = 1'b1; m_rdata = 32'hA000 + 32'(i); m_rlast = (i == 15);
            if (i == 3) begin
                n_assert++;
                if (fifo_wr !== 1'b1) begin n_fail++; $error("FAIL t1_fifo_wr: observed 0x%0h expected 0x1", fifo_wr); end
                n_assert++;
                if (fifo_din !== 32'hA003) begin n_fail++; $error("FAIL t1_fifo_din: observed 0x%0h expected 0xa003", fifo_din); end
            end
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        tick();
        n_assert++;
        if ((n_wr - wr0) !== 16) begin n_fail++; $error("FAIL t1_wr_count: observed %0d expected 16", n_wr - wr0); end
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $error("FAIL t1_err: observed 0x%0h expected 0x0", err); end

        // Second request held pending while AR stalls; third one overflows
        do_reset();
        m_arready = 1'b0;
        start_frame(BASE);
        hstart = 1'b1; tick(); hstart = 1'b0;
        n_assert++;
        if (m_arvalid !== 1'b1) begin n_fail++; $error("FAIL t2_arvalid: observed 0x%0h expected 0x1", m_arvalid); end
        n_assert++;
        if (m_araddr !== BASE) begin n_fail++; $error("FAIL t2_araddr0: observed 0x%0h expected 0x%0h", m_araddr, BASE); end
        tick();
        hstart = 1'b1; tick(); hstart = 1'b0;
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $error("FAIL t2_err_pending: observed 0x%0h expected 0x0", err); end
        n_assert++;
        if (m_araddr !== BASE) begin n_fail++; $error("FAIL t2_araddr_held: observed 0x%0h expected 0x%0h", m_araddr, BASE); end
        hstart = 1'b1; tick(); hstart = 1'b0;
        n_assert++;
        if (err !== 1'b1) begin n_fail++; $error("FAIL t2_err_overflow: observed 0x%0h expected 0x1", err); end
        tick();
        m_arready = 1'b1;
        tick();
        n_assert++;
        if (arready !== 1'b1) begin n_fail++; $error("FAIL t2_hs_arready: observed 0x%0h expected 0x1", arready); end
        n_assert++;
        if (m_arvalid !== 1'b0) begin n_fail++; $error("FAIL t2_hs_arvalid: observed 0x%0h expected 0x0", m_arvalid); end
        tick();
        n_assert++;
        if (m_arvalid !== 1'b1) begin n_fail++; $error("FAIL t2_second_arvalid: observed 0x%0h expected 0x1", m_arvalid); end
        n_assert++;
        if (m_araddr !== BASE + 32'h40) begin n_fail++; $error("FAIL t2_second_araddr: observed 0x%0h expected 0x%0h", m_araddr, BASE + 32'h40); end

        // Outstanding limit: four bursts issue, fifth waits for an RLAST
        do_reset();
        m_arready = 1'b1;
        start_frame(BASE);
        a0 = n_arrdy;
        for (int k = 0; k < 5; k++) begin
            hstart = 1'b1; tick(); hstart = 1'b0; tick();
        end
        tick();
        n_assert++;
        if (m_arvalid !== 1'b0) begin n_fail++; $error("FAIL t3_blocked_arvalid: observed 0x%0h expected 0x0", m_arvalid); end
        n_assert++;
        if ((n_arrdy - a0) !== 4) begin n_fail++; $error("FAIL t3_hs_count: observed %0d expected 4", n_arrdy - a0); end
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $error("FAIL t3_err: observed 0x%0h expected 0x0", err); end
        m_rvalid = 1'b1; m_rlast = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        tick();
        n_assert++;
        if (m_arvalid !== 1'b1) begin n_fail++; $error("FAIL t3_fifth_arvalid: observed 0x%0h expected 0x1", m_arvalid); end
        n_assert++;
        if (m_araddr !== BASE + 32'h100) begin n_fail++; $error("FAIL t3_fifth_araddr: observed 0x%0h expected 0x%0h", m_araddr, BASE + 32'h100); end

        // FIFO almost-full backpressure mid-burst
        do_reset();
        m_arready = 1'b1;
        start_frame(BASE);
        hstart = 1'b1; tick(); hstart = 1'b0; tick();
        wr0 = n_wr; b = 0;
        for (int c = 0; c < 40 && b < 16; c++) begin
            fifo_afull = (c >= 5 && c < 8);
            m_rvalid = 1'b1; m_rdata = 32'hB000 + 32'(b); m_rlast = (b == 15);
            if (c == 6) begin
                n_assert++;
                if (m_rready !== 1'b0) begin n_fail++; $error("FAIL t4_rready_stall: observed 0x%0h expected 0x0", m_rready); end
                n_assert++;
                if (fifo_wr !== 1'b0) begin n_fail++; $error("FAIL t4_wr_stall: observed 0x%0h expected 0x0", fifo_wr); end
            end
            if (c == 8) begin
                n_assert++;
                if (fifo_din !== 32'hB005) begin n_fail++; $error("FAIL t4_din_resume: observed 0x%0h expected 0xb005", fifo_din); end
            end
            tick();
            if (!fifo_afull) b++;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; fifo_afull = 1'b0;
        tick();
        n_assert++;
        if ((n_wr - wr0) !== 16) begin n_fail++; $error("FAIL t4_wr_count: observed %0d expected 16", n_wr - wr0); end
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $error("FAIL t4_err: observed 0x%0h expected 0x0", err); end

        // Error response on beat 7 is sticky until reset
        do_reset();
        m_arready = 1'b1;
        start_frame(BASE);
        hstart = 1'b1; tick(); hstart = 1'b0; tick();
        for (int i = 0; i < 16; i++) begin
            m_rvalid = 1'b1; m_rlast = (i == 15); m_rresp = (i == 7) ? 2'b10 : 2'b00;
            if (i == 7) begin
                n_assert++;
                if (err !== 1'b0) begin n_fail++; $error("FAIL t6_err_before: observed 0x%0h expected 0x0", err); end
            end
            tick();
            if (i == 7) begin
                n_assert++;
                if (err !== 1'b1) begin n_fail++; $error("FAIL t6_err_set: observed 0x%0h expected 0x1", err); end
            end
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
        tick();
        n_assert++;
        if (err !== 1'b1) begin n_fail++; $error("FAIL t6_err_sticky: observed 0x%0h expected 0x1", err); end
        hstart = 1'b1; tick(); hstart = 1'b0;
        n_assert++;
        if (m_arvalid !== 1'b1) begin n_fail++; $error("FAIL t6_continue_arvalid: observed 0x%0h expected 0x1", m_arvalid); end
        n_assert++;
        if (m_araddr !== BASE + 32'h40) begin n_fail++; $error("FAIL t6_continue_araddr: observed 0x%0h expected 0x%0h", m_araddr, BASE + 32'h40); end
        RST = 1'b1; tick(); RST = 1'b0;
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $error("FAIL t6_rst_err: observed 0x%0h expected 0x0", err); end

        // Full frame: one RLAST beat closes each burst
        do_reset();
        m_arready = 1'b1;
        start_frame(BASE);
        d0 = n_done; miss = 0; last_addr = '0;
        for (int k = 0; k < 9600; k++) begin
            hstart = 1'b1; tick(); hstart = 1'b0;
            last_addr = m_araddr;
            if (m_araddr !== BASE + 32'(k) * 32'd64) miss++;
            tick();
            m_rvalid = 1'b1; m_rlast = 1'b1;
            tick();
            m_rvalid = 1'b0; m_rlast = 1'b0;
        end
        n_assert++;
        if (frame_done !== 1'b1) begin n_fail++; $error("FAIL t5_frame_done: observed 0x%0h expected 0x1", frame_done); end
        n_assert++;
        if (last_addr !== BASE + 32'h95FC0) begin n_fail++; $error("FAIL t5_last_araddr: observed 0x%0h expected 0x%0h", last_addr, BASE + 32'h95FC0); end
        n_assert++;
        if (miss !== 0) begin n_fail++; $error("FAIL t5_addr_misses: observed %0d expected 0", miss); end
        a0 = n_arrdy;
        hstart = 1'b1; tick(); hstart = 1'b0;
        n_assert++;
        if (frame_done !== 1'b0) begin n_fail++; $error("FAIL t5_done_pulse_end: observed 0x%0h expected 0x0", frame_done); end
        tick(); tick();
        n_assert++;
        if (m_arvalid !== 1'b0) begin n_fail++; $error("FAIL t5_post_arvalid: observed 0x%0h expected 0x0", m_arvalid); end
        n_assert++;
        if ((n_arrdy - a0) !== 0) begin n_fail++; $error("FAIL t5_post_hs: observed %0d expected 0", n_arrdy - a0); end
        n_assert++;
        if ((n_done - d0) !== 1) begin n_fail++; $error("FAIL t5_done_once: observed %0d expected 1", n_done - d0); end
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $error("FAIL t5_err: observed 0x%0h expected 0x0", err); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
